// File: rtl/scale_fifo_line_rd_sched.sv
// Line-burst read scheduler between the synchronous scale FIFO and the scaler core.
// Latency: first read 2 cycles after start; first pixel READ_LAT+1 cycles after its read.
// Backpressure: out_ready stalls the skid head. Reads stop while skid_occ + inflight would exceed 4.
//
// Ports:
//   clk, rst_n          - single clock, synchronous active-low reset
//   start, abort        - frame start pulse (only honoured in IDLE) / frame abort pulse
//   fifo_rd_*           - FIFO read port: enable, data (READ_LAT later), empty flag, occupancy
//   out_data/valid/ready- pixel stream to the scaler, with out_sof / out_eol tags
//   busy, frame_done    - not-idle status, one-cycle pulse after the last pixel is accepted
//   line_cnt            - lines fully accepted downstream in the current frame
module scale_fifo_line_rd_sched #(
    parameter int RD_DATA_WIDTH  = 32,
    parameter int RD_DEPTH_WIDTH = 10,
    parameter int LINE_PIX       = 640,
    parameter int FRAME_LINES    = 480,
    parameter int READ_LAT       = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    output logic                      fifo_rd_en,
    input  logic [RD_DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic                      fifo_rd_empty,
    input  logic [RD_DEPTH_WIDTH:0]   fifo_rd_water_level,
    output logic [RD_DATA_WIDTH-1:0]  out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_sof,
    output logic                      out_eol,
    output logic                      busy,
    output logic                      frame_done,
    output logic [11:0]               line_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LINE,
        BURST,
        DRAIN,
        FLUSH
    } state_t;

    // Comparison width wide enough for both the water level and a 12-bit line length.
    localparam int CMP_W = (RD_DEPTH_WIDTH + 1 > 13) ? RD_DEPTH_WIDTH + 1 : 13;
    localparam logic [CMP_W-1:0] LINE_PIX_C = CMP_W'(LINE_PIX);
    localparam logic [11:0]      LAST_PIX   = 12'(LINE_PIX - 1);
    localparam logic [11:0]      LAST_LINE  = 12'(FRAME_LINES - 1);
    localparam int               SKID_W     = RD_DATA_WIDTH + 2;

    state_t                 state;
    logic                   rd_en_q;
    logic                   first_rd;
    logic                   frame_done_q;
    logic [11:0]            rd_cnt;
    logic [11:0]            lines_issued;
    logic [11:0]            line_cnt_q;
    logic [1:0]             flush_cnt;

    // Tag pipe: one stage per cycle of FIFO read latency, aligned with returning data.
    logic [READ_LAT-1:0]    pipe_v;
    logic [READ_LAT-1:0]    pipe_sof;
    logic [READ_LAT-1:0]    pipe_eol;

    // Skid buffer entries are {sof, eol, data}.
    logic [SKID_W-1:0]      skid_mem [4];
    logic [1:0]             wr_ptr;
    logic [1:0]             rd_ptr;
    logic [2:0]             skid_occ;

    logic                   abort_act;
    logic                   rd;
    logic                   pop;
    logic                   wr;
    logic                   last_rd;
    logic                   water_ok;
    logic                   credit_ok;
    logic [2:0]             inflight;
    logic [3:0]             credit_sum;
    logic [SKID_W-1:0]      head;

    always_comb begin
        abort_act = abort && (state != IDLE);
        // rd_en_q holds the schedule decided last cycle; empty and abort veto it
        // combinationally so a read is never issued into an empty FIFO or an abort.
        rd        = rd_en_q && !fifo_rd_empty && !abort_act;
        last_rd   = rd && (rd_cnt == LAST_PIX);
        head      = skid_mem[rd_ptr];
        pop       = (skid_occ != 3'd0) && out_ready;
        wr        = pipe_v[READ_LAT-1] && !abort_act;
        water_ok  = CMP_W'(fifo_rd_water_level) >= LINE_PIX_C;
        inflight  = 3'd0;
        for (int i = 0; i < READ_LAT; i++) begin
            inflight = inflight + 3'(pipe_v[i]);
        end
        // Credit as it will stand next cycle: this cycle's read adds one, a pop frees one,
        // a skid write just moves an entry from inflight to occupancy.
        credit_sum = 4'(skid_occ) + 4'(inflight) + 4'(rd) - 4'(pop);
        credit_ok  = credit_sum < 4'd4;
    end

    assign fifo_rd_en = rd;
    assign out_valid  = (skid_occ != 3'd0);
    assign out_data   = head[RD_DATA_WIDTH-1:0];
    assign out_sof    = out_valid && head[SKID_W-1];
    assign out_eol    = out_valid && head[SKID_W-2];
    assign busy       = (state != IDLE);
    assign frame_done = frame_done_q;
    assign line_cnt   = line_cnt_q;

    // Tag pipe. Abort drops everything still in flight; FLUSH then waits out the data.
    always_ff @(posedge clk) begin
        if (!rst_n || abort_act) begin
            pipe_v   <= '0;
            pipe_sof <= '0;
            pipe_eol <= '0;
        end else begin
            pipe_v[0]   <= rd;
            pipe_sof[0] <= rd && first_rd;
            pipe_eol[0] <= last_rd;
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_sof[i] <= pipe_sof[i-1];
                pipe_eol[i] <= pipe_eol[i-1];
            end
        end
    end

    // Skid buffer. Sized 4 so the credit limit can never overflow it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                skid_mem[k] <= '0;
            end
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            skid_occ <= 3'd0;
        end else if (abort_act) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            skid_occ <= 3'd0;
        end else begin
            if (wr) begin
                skid_mem[wr_ptr] <= {pipe_sof[READ_LAT-1], pipe_eol[READ_LAT-1], fifo_rd_data};
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            skid_occ <= skid_occ + 3'(wr) - 3'(pop);
        end
    end

    // Control FSM with registered read schedule, counters and frame_done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            rd_en_q      <= 1'b0;
            first_rd     <= 1'b0;
            frame_done_q <= 1'b0;
            rd_cnt       <= 12'd0;
            lines_issued <= 12'd0;
            line_cnt_q   <= 12'd0;
            flush_cnt    <= 2'd0;
        end else begin
            rd_en_q      <= 1'b0;
            frame_done_q <= 1'b0;

            if (pop && out_eol) begin
                line_cnt_q <= line_cnt_q + 12'd1;
            end
            if (rd) begin
                first_rd <= 1'b0;
                rd_cnt   <= last_rd ? 12'd0 : rd_cnt + 12'd1;
            end
            if (last_rd) begin
                lines_issued <= lines_issued + 12'd1;
            end

            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state        <= WAIT_LINE;
                        rd_cnt       <= 12'd0;
                        lines_issued <= 12'd0;
                        line_cnt_q   <= 12'd0;
                        first_rd     <= 1'b1;
                    end
                end
                WAIT_LINE: begin
                    if (abort) begin
                        state     <= FLUSH;
                        flush_cnt <= 2'(READ_LAT - 1);
                    end else if (water_ok) begin
                        state   <= BURST;
                        rd_en_q <= credit_ok;
                    end
                end
                BURST: begin
                    if (abort) begin
                        state     <= FLUSH;
                        flush_cnt <= 2'(READ_LAT - 1);
                    end else if (last_rd) begin
                        // lines_issued still holds the pre-increment count here.
                        state <= (lines_issued == LAST_LINE) ? DRAIN : WAIT_LINE;
                    end else begin
                        rd_en_q <= credit_ok;
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state     <= FLUSH;
                        flush_cnt <= 2'(READ_LAT - 1);
                    end else if (pop && out_eol && (line_cnt_q == LAST_LINE)) begin
                        frame_done_q <= 1'b1;
                        state        <= IDLE;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == 2'd0) begin
                        state <= IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/scale_fifo_line_rd_sched.md
# scale_fifo_line_rd_sched

Line-burst read scheduler for the synchronous scale FIFO feeding the video scaler. It waits until a complete line of pixels is buffered, then drains exactly one line per burst with full-rate reads, absorbs the FIFO read latency in a 4-entry skid buffer so downstream backpressure never loses data, and tags each pixel with start-of-frame and end-of-line flags. It sits between the scale FIFO read port and the scaler core and sequences one frame of LINE_PIX × FRAME_LINES pixels per start command.

## Interface
Parameters:
- RD_DATA_WIDTH, 32, pixel word width; matches the FIFO read data width.
- RD_DEPTH_WIDTH, 10, FIFO read depth width; the water-level input is RD_DEPTH_WIDTH+1 bits.
- LINE_PIX, 640, pixels per line; legal range 1..min(4095, 2^RD_DEPTH_WIDTH).
- FRAME_LINES, 480, lines per frame; legal range 1..4095.
- READ_LAT, 1, FIFO read latency in cycles; 1 without output register, 2 with; legal values 1 or 2.

Ports:
- clk  in  1  single clock, shared with both FIFO ports (synchronous FIFO type).
- rst_n  in  1  synchronous reset, active low.
- start  in  1  one-cycle pulse that begins a frame; ignored unless idle.
- abort  in  1  one-cycle pulse that stops the frame and discards in-flight data.
- fifo_rd_en  out  1  FIFO read enable.
- fifo_rd_data  in  RD_DATA_WIDTH  FIFO read data, valid READ_LAT cycles after fifo_rd_en.
- fifo_rd_empty  in  1  FIFO empty flag.
- fifo_rd_water_level  in  RD_DEPTH_WIDTH+1  FIFO read-side occupancy, in words.
- out_data  out  RD_DATA_WIDTH  pixel to the scaler.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  scaler accepts the pixel when out_valid=1 and out_ready=1.
- out_sof  out  1  first pixel of the frame; qualified by out_valid.
- out_eol  out  1  last pixel of a line; qualified by out_valid.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse when the last pixel of the frame is accepted.
- line_cnt  out  12  number of lines fully accepted in the current frame.

## Operation
- States: IDLE, WAIT_LINE, BURST, DRAIN, FLUSH.
- IDLE: start moves the block to WAIT_LINE and clears the read counter rd_cnt, the issued-line counter and line_cnt.
- WAIT_LINE: when fifo_rd_water_level >= LINE_PIX, move to BURST on the next cycle. Otherwise hold.
- BURST:
  - fifo_rd_en = !fifo_rd_empty && (skid_occ + inflight) < 4.
  - Each read increments rd_cnt and pushes a tag {sof, eol} into a READ_LAT-deep tag pipe.
  - sof = first read of the frame; eol = (rd_cnt == LINE_PIX-1).
  - After the read with eol: clear rd_cnt and increment the issued-line counter.
  - If that line was line FRAME_LINES, go to DRAIN; otherwise go to WAIT_LINE.
- Returning data and its tag are written into the skid buffer. out_* presents the skid head; the head is popped on out_valid && out_ready.
- line_cnt increments on each accepted pixel with out_eol.
- DRAIN: issues no reads. When the final eol pixel is accepted: pulse frame_done and go to IDLE.
- abort in any non-IDLE state:
  - fifo_rd_en is deasserted in the same cycle.
  - The skid buffer is cleared and out_valid drops next cycle.
  - The block enters FLUSH for READ_LAT cycles, discarding returning data, then goes to IDLE.
  - frame_done is not pulsed.
- Simultaneous start and abort in IDLE: abort wins and the block stays IDLE.
- The credit limit (skid_occ + inflight ≤ 4) guarantees no skid overflow for READ_LAT ≤ 2 and allows 1 pixel/cycle when out_ready is held high.

## Timing
- Reset values (rst_n=0 at a clk edge): state IDLE, fifo_rd_en=0, out_valid=0, out_sof=0, out_eol=0, out_data=0, busy=0, frame_done=0, line_cnt=0, all counters and skid pointers 0.
- fifo_rd_en is registered.
  - The first read is issued 2 cycles after start when the water level is already sufficient: start → WAIT_LINE → BURST.
  - The first out_valid follows the first read by READ_LAT+1 cycles, because the skid write is registered.
- Steady state with out_ready=1: one pixel per cycle, with no bubble inside a line.
- Gap between lines is at least 1 cycle (BURST → WAIT_LINE → BURST).
- frame_done is registered and asserts the cycle after the final handshake.
- busy falls in that same cycle.

## Test plan
- Line flags: LINE_PIX=4, FRAME_LINES=2, READ_LAT=1, FIFO preloaded with 8 words, out_ready=1 → exactly 8 out_valid beats; out_sof on beat 0 only; out_eol on beats 3 and 7; frame_done 1 cycle after beat 7; line_cnt=2.
- Water-level gating: water level held at LINE_PIX-1 → fifo_rd_en stays 0. Raising it to LINE_PIX → first fifo_rd_en 1 cycle later.
- Backpressure: READ_LAT=2, out_ready toggling 1010… → no pixel lost or duplicated, data order preserved, skid_occ + inflight never exceeds 4.
- Throughput: READ_LAT=2, out_ready=1, LINE_PIX=16 → 16 consecutive out_valid beats per line.
- Abort mid-burst: abort after 3 of 8 reads → fifo_rd_en=0 in the same cycle; out_valid=0 next cycle; busy falls after READ_LAT+1 cycles; no frame_done.
- Reset and start while busy: rst_n=0 mid-burst → all outputs at reset values next cycle. A start pulse during BURST → ignored, and the frame length is unchanged.
